// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: instruction-cache address fields, cache FSM states
// and a saturating counter helper.
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = 4;
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read, one synchronous write, clear-all-valid; only valid bits reset.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data,
    input  logic             clr_all
);

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [31:0]      data_mem [SETS];

    // Clear wins over a same-cycle write so an aborted fill never lands.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
        end else if (clr_all) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: zero-latency hits, single-word refill on miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_responder
    import cpu_types_pkg::*;
#(
    parameter  int SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        inval,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic        iwait
);

    icache_state_t    state, next_state;
    logic [29:0]      miss_addr;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             tag_match;
    logic             fill_done;
    logic             start_miss;
    logic             unused_bytoff;

    assign req_tag       = imemaddr[31:IDX_W+2];
    assign req_idx       = imemaddr[IDX_W+1:2];
    assign unused_bytoff = ^imemaddr[1:0];

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_done),
        .wr_idx   (miss_addr[IDX_W-1:0]),
        .wr_tag   (miss_addr[29:IDX_W]),
        .wr_data  (iload),
        .clr_all  (inval)
    );

    assign tag_match = rd_valid && (rd_tag == req_tag);

    always_comb begin
        next_state = state;
        ihit       = 1'b0;
        iREN       = 1'b0;
        iaddr      = '0;
        fill_done  = 1'b0;
        start_miss = 1'b0;
        case (state)
            IDLE: begin
                ihit = imemREN && tag_match && !inval;
                if (imemREN && !tag_match && !inval) begin
                    start_miss = 1'b1;
                    next_state = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = {miss_addr, 2'b00};
                if (inval) begin
                    next_state = IDLE;
                end else if (!iwait) begin
                    fill_done  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign imemload = ihit ? rd_data : 32'd0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state <= next_state;
            if (start_miss) begin
                miss_addr <= imemaddr[31:2];
            end
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (inval) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (ihit) begin
                hit_count <= sat_inc32(hit_count);
            end
            if (start_miss) begin
                miss_count <= sat_inc32(miss_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed vector table, hand-written
// abort/reset sequences, and randomized traffic against a word-address cache model.
module tb_icache_responder;
    import cpu_types_pkg::*;

    localparam int SETS  = 16;
    localparam int IDX_W = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        imemREN = 1'b0;
    logic [31:0] imemaddr = '0;
    logic        ihit;
    logic [31:0] imemload;
    logic        inval = 1'b0;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload = '0;
    logic        iwait = 1'b1;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int total = 0;
    int bad   = 0;

    icache_responder #(.SETS(SETS)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .inval    (inval),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
`ifdef ICACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .iwait    (iwait)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren;
        logic [31:0] addr;
        logic        inv;
        logic        wt;
        logic [31:0] ld;
        logic        ehit;
        logic [31:0] eload;
        logic        eiren;
        logic [31:0] eiaddr;
    } vec_t;

    vec_t vecs [14];

    // Reference model: per index, the cached word address and its data.
    logic        m_valid [SETS];
    logic [29:0] m_wa    [SETS];
    logic [31:0] m_data  [SETS];
    logic        m_pend;
    logic [29:0] m_pend_wa;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ren, input logic [31:0] addr, input logic inv,
                         input logic wt, input logic [31:0] ld);
        imemREN  = ren;
        imemaddr = addr;
        inval    = inv;
        iwait    = wt;
        iload    = ld;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, then advance past the edge.
    task automatic step(input string name, input logic ren, input logic [31:0] addr,
                        input logic inv, input logic wt, input logic [31:0] ld,
                        input logic ehit, input logic [31:0] eload,
                        input logic eiren, input logic [31:0] eiaddr);
        drive(ren, addr, inv, wt, ld);
        #4;
        chk({name, ".ihit"},     {31'd0, ihit}, {31'd0, ehit});
        chk({name, ".imemload"}, imemload,      eload);
        chk({name, ".iREN"},     {31'd0, iREN}, {31'd0, eiren});
        chk({name, ".iaddr"},    iaddr,         eiaddr);
        next_cycle();
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        return ({2'b00, wa} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mk_addr(input int tag, input int idx, input int off);
        icachef_t f;
        f.tag    = ICACHE_TAG_W'(tag);
        f.idx    = ICACHE_IDX_W'(idx);
        f.bytoff = 2'(off);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        m_pend    = 1'b0;
        m_pend_wa = '0;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'd0);
        RST = 1'b1;
        next_cycle();
        next_cycle();
        RST = 1'b0;
        model_reset();
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[2]  = '{1'b0, 32'h44, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[3]  = '{1'b1, 32'h80, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b1, 32'h40};
        vecs[4]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h2002_0005, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[5]  = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2002_0005, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 32'h42, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2002_0005, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[8]  = '{1'b1, 32'h80, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[9]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'hAAAA_0080, 1'b0, 32'h0,         1'b1, 32'h80};
        vecs[10] = '{1'b1, 32'h83, 1'b0, 1'b1, 32'h0,         1'b1, 32'hAAAA_0080, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0};
        vecs[12] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h2002_0005, 1'b0, 32'h0,         1'b1, 32'h40};
        vecs[13] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h0,         1'b1, 32'h2002_0005, 1'b0, 32'h0};

        // Reset state, including a request presented while reset is held.
        drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
        #3;
        chk("rst.ihit",     {31'd0, ihit}, 32'd0);
        chk("rst.imemload", imemload,      32'd0);
        chk("rst.iREN",     {31'd0, iREN}, 32'd0);
        chk("rst.iaddr",    iaddr,         32'd0);
        do_reset();

        // Cold miss, hits, offset-insensitive hit, conflict refills.
        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), vecs[i].ren, vecs[i].addr, vecs[i].inv, vecs[i].wt,
                 vecs[i].ld, vecs[i].ehit, vecs[i].eload, vecs[i].eiren, vecs[i].eiaddr);
        end

        // Abort: inval during fill of 0x100 drops iREN and wipes 0x40.
        step("abort.req",  1'b1, 32'h100, 1'b0, 1'b1, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0);
        step("abort.inv",  1'b0, 32'h0,   1'b1, 1'b0, 32'hDEAD, 1'b0, 32'h0, 1'b1, 32'h100);
        step("abort.idle", 1'b0, 32'h100, 1'b0, 1'b1, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0);
        step("abort.re100",1'b1, 32'h100, 1'b0, 1'b1, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0);
        step("abort.fill", 1'b1, 32'h100, 1'b0, 1'b0, 32'h1234, 1'b0, 32'h0, 1'b1, 32'h100);
        step("abort.hit",  1'b1, 32'h100, 1'b0, 1'b1, 32'h0,    1'b1, 32'h1234, 1'b0, 32'h0);
        step("abort.re40", 1'b1, 32'h40,  1'b0, 1'b1, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0);
        step("abort.f40",  1'b1, 32'h40,  1'b0, 1'b0, 32'h2002_0005, 1'b0, 32'h0, 1'b1, 32'h40);
        // inval in IDLE masks a would-be hit and wipes the frame.
        step("idleinv.hit",1'b1, 32'h40,  1'b1, 1'b1, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0);
        step("idleinv.mis",1'b1, 32'h40,  1'b0, 1'b1, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0);
        step("idleinv.f",  1'b0, 32'h0,   1'b0, 1'b0, 32'h2002_0005, 1'b0, 32'h0, 1'b1, 32'h40);
        step("idleinv.rh", 1'b1, 32'h44,  1'b0, 1'b1, 32'h0,    1'b0, 32'h0, 1'b0, 32'h0);

        // Reset mid-fill: iREN drops asynchronously; cached 0x40 is lost.
        step("rstfill.in", 1'b1, 32'h44,  1'b0, 1'b1, 32'h0,    1'b0, 32'h0, 1'b1, 32'h44);
        RST = 1'b1;
        #1;
        chk("rstfill.iREN", {31'd0, iREN}, 32'd0);
        chk("rstfill.ihit", {31'd0, ihit}, 32'd0);
        chk("rstfill.iaddr", iaddr, 32'd0);
        next_cycle();
        RST = 1'b0;
        step("rstfill.m40", 1'b1, 32'h40, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("rstfill.f40", 1'b0, 32'h0,  1'b0, 1'b0, 32'h77, 1'b0, 32'h0, 1'b1, 32'h40);

`ifdef ICACHE_STATS_EN
        do_reset();
        step("st.miss", 1'b1, 32'h40, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step("st.fill", 1'b1, 32'h40, 1'b0, 1'b0, 32'h55, 1'b0, 32'h0, 1'b1, 32'h40);
        for (int i = 0; i < 3; i++)
            step("st.hit", 1'b1, 32'h40, 1'b0, 1'b1, 32'h0, 1'b1, 32'h55, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        #4;
        chk("st.miss_count", miss_count, 32'd1);
        chk("st.hit_count",  hit_count,  32'd3);
        next_cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        next_cycle();
        inval = 1'b0;
        #4;
        chk("st.miss_clr", miss_count, 32'd0);
        chk("st.hit_clr",  hit_count,  32'd0);
        next_cycle();
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic        ren, inv, wt, ehit, eiren;
            logic [31:0] addr, ld, eload, eiaddr;
            int          idx;
            ren  = ($urandom_range(3) != 0);
            addr = mk_addr($urandom_range(3) + 1, $urandom_range(SETS - 1), $urandom_range(3));
            inv  = ($urandom_range(24) == 0);
            wt   = $urandom_range(1) == 1;
            ld   = m_pend ? mem_word(m_pend_wa) : $urandom();
            idx  = int'(addr[IDX_W+1:2]);

            ehit   = 1'b0;
            eload  = 32'd0;
            eiren  = m_pend;
            eiaddr = m_pend ? {m_pend_wa, 2'b00} : 32'd0;
            if (!m_pend && ren && !inv && m_valid[idx] && m_wa[idx] == addr[31:2]) begin
                ehit  = 1'b1;
                eload = m_data[idx];
            end

            drive(ren, addr, inv, wt, ld);
            #4;
            chk("rnd.ihit",     {31'd0, ihit}, {31'd0, ehit});
            chk("rnd.imemload", imemload,      eload);
            chk("rnd.iREN",     {31'd0, iREN}, {31'd0, eiren});
            chk("rnd.iaddr",    iaddr,         eiaddr);

            if (inv) begin
                for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (!wt) begin
                    m_valid[int'(m_pend_wa[IDX_W-1:0])] = 1'b1;
                    m_wa[int'(m_pend_wa[IDX_W-1:0])]    = m_pend_wa;
                    m_data[int'(m_pend_wa[IDX_W-1:0])]  = ld;
                    m_pend = 1'b0;
                end
            end else if (ren && !ehit) begin
                m_pend    = 1'b1;
                m_pend_wa = addr[31:2];
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
